// File: rtl/vx_writeback_arbiter.sv
// Writeback arbiter: drops non-writing commits and round-robins the writing commits
// onto one registered writeback bus. Define WB_PERF_EN to add the perf_wb_stalls counter.
module vx_writeback_arbiter #(
  parameter int NUM_REQS      = 5,
  parameter int NUM_THREADS   = 4,
  parameter int NUM_WARPS     = 4,
  parameter int UUID_BITS     = 44,
  parameter int RD_BITS       = 5,
  parameter int PERF_CTR_BITS = 44,
  localparam int WID_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQS-1:0]               commit_valid,
  output logic [NUM_REQS-1:0]               commit_ready,
  input  logic [NUM_REQS*UUID_BITS-1:0]     commit_uuid,
  input  logic [NUM_REQS*WID_W-1:0]         commit_wid,
  input  logic [NUM_REQS*32-1:0]            commit_PC,
  input  logic [NUM_REQS*NUM_THREADS-1:0]   commit_tmask,
  input  logic [NUM_REQS-1:0]               commit_wb,
  input  logic [NUM_REQS*RD_BITS-1:0]       commit_rd,
  input  logic [NUM_REQS*NUM_THREADS*32-1:0] commit_data,
  input  logic [NUM_REQS-1:0]               commit_eop,
`ifdef WB_PERF_EN
  output logic [PERF_CTR_BITS-1:0]          perf_wb_stalls,
`endif
  output logic                              writeback_valid,
  output logic [UUID_BITS-1:0]              writeback_uuid,
  output logic [WID_W-1:0]                  writeback_wid,
  output logic [31:0]                       writeback_PC,
  output logic [NUM_THREADS-1:0]            writeback_tmask,
  output logic [RD_BITS-1:0]                writeback_rd,
  output logic [NUM_THREADS*32-1:0]         writeback_data,
  output logic                              writeback_eop
);

  localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int CNT_W = $clog2(NUM_REQS + 1);
  localparam int DW    = NUM_THREADS * 32;

  logic [NUM_REQS-1:0]    wr_req_s, drop_req_s, grant_oh_s;
  logic [PTR_W-1:0]       grant_idx_s;
  logic                   grant_any_s;
  logic [CNT_W-1:0]       n_wr_s;

  logic [PTR_W-1:0]       rr_ptr_d, rr_ptr_q;
  logic                   valid_d, valid_q;
  logic [UUID_BITS-1:0]   uuid_d, uuid_q;
  logic [WID_W-1:0]       wid_d, wid_q;
  logic [31:0]            pc_d, pc_q;
  logic [NUM_THREADS-1:0] tmask_d, tmask_q;
  logic [RD_BITS-1:0]     rd_d, rd_q;
  logic [DW-1:0]          data_d, data_q;
  logic                   eop_d, eop_q;
`ifdef WB_PERF_EN
  logic [PERF_CTR_BITS-1:0] stalls_d, stalls_q;
`endif

  // Request classification, round-robin grant, ready generation and next-state.
  always_comb begin
    wr_req_s    = commit_valid & commit_wb;
    drop_req_s  = commit_valid & ~commit_wb;
    grant_oh_s  = '0;
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    n_wr_s      = '0;
    rr_ptr_d    = rr_ptr_q;
    valid_d     = 1'b0;
    uuid_d      = uuid_q;
    wid_d       = wid_q;
    pc_d        = pc_q;
    tmask_d     = tmask_q;
    rd_d        = rd_q;
    data_d      = data_q;
    eop_d       = eop_q;

    for (int j = 0; j < NUM_REQS; j++) begin
      int idx;
      idx = (int'(rr_ptr_q) + j) % NUM_REQS;
      if (!grant_any_s && wr_req_s[idx]) begin
        grant_any_s     = 1'b1;
        grant_idx_s     = PTR_W'(idx);
        grant_oh_s[idx] = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
      if (wr_req_s[j]) begin
        n_wr_s = n_wr_s + CNT_W'(1);
      end else begin
        n_wr_s = n_wr_s;
      end
    end

    // Ready never looks downstream: the writeback bus cannot stall.
    if (reset) begin
      commit_ready = '0;
    end else begin
      commit_ready = drop_req_s | grant_oh_s;
    end

    if (grant_any_s) begin
      valid_d  = 1'b1;
      rr_ptr_d = (grant_idx_s == PTR_W'(NUM_REQS - 1)) ? '0 : grant_idx_s + PTR_W'(1);
      uuid_d   = commit_uuid[int'(grant_idx_s)*UUID_BITS +: UUID_BITS];
      wid_d    = commit_wid[int'(grant_idx_s)*WID_W +: WID_W];
      pc_d     = commit_PC[int'(grant_idx_s)*32 +: 32];
      tmask_d  = commit_tmask[int'(grant_idx_s)*NUM_THREADS +: NUM_THREADS];
      rd_d     = commit_rd[int'(grant_idx_s)*RD_BITS +: RD_BITS];
      data_d   = commit_data[int'(grant_idx_s)*DW +: DW];
      eop_d    = commit_eop[grant_idx_s];
    end else begin
      valid_d  = 1'b0;
    end

`ifdef WB_PERF_EN
    if (n_wr_s > CNT_W'(1)) begin
      stalls_d = stalls_q + PERF_CTR_BITS'(1);
    end else begin
      stalls_d = stalls_q;
    end
`endif
  end

  // Pointer and writeback register stage; reset discards any in-flight entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      uuid_q   <= '0;
      wid_q    <= '0;
      pc_q     <= '0;
      tmask_q  <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      eop_q    <= 1'b0;
`ifdef WB_PERF_EN
      stalls_q <= '0;
`endif
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      uuid_q   <= uuid_d;
      wid_q    <= wid_d;
      pc_q     <= pc_d;
      tmask_q  <= tmask_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      eop_q    <= eop_d;
`ifdef WB_PERF_EN
      stalls_q <= stalls_d;
`endif
    end
  end

  assign writeback_valid = valid_q;
  assign writeback_uuid  = uuid_q;
  assign writeback_wid   = wid_q;
  assign writeback_PC    = pc_q;
  assign writeback_tmask = tmask_q;
  assign writeback_rd    = rd_q;
  assign writeback_data  = data_q;
  assign writeback_eop   = eop_q;
`ifdef WB_PERF_EN
  assign perf_wb_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Scoreboard bench for vx_writeback_arbiter: a reference round-robin model pushes
// expected writebacks at grant time; they are popped and compared one cycle later.
module tb_vx_writeback_arbiter;

  localparam int N = 5;

  typedef struct packed {
    logic [43:0]  uuid;
    logic [1:0]   wid;
    logic [31:0]  pc;
    logic [3:0]   tmask;
    logic [4:0]   rd;
    logic [127:0] data;
    logic         eop;
  } wb_t;

  logic           clk;
  logic           reset;
  logic [N-1:0]   commit_valid, commit_ready, commit_wb, commit_eop;
  logic [N*44-1:0]  commit_uuid;
  logic [N*2-1:0]   commit_wid;
  logic [N*32-1:0]  commit_PC;
  logic [N*4-1:0]   commit_tmask;
  logic [N*5-1:0]   commit_rd;
  logic [N*128-1:0] commit_data;
  logic           writeback_valid, writeback_eop;
  logic [43:0]    writeback_uuid;
  logic [1:0]     writeback_wid;
  logic [31:0]    writeback_PC;
  logic [3:0]     writeback_tmask;
  logic [4:0]     writeback_rd;
  logic [127:0]   writeback_data;
`ifdef WB_PERF_EN
  logic [43:0]    perf_wb_stalls;
`endif

  vx_writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_uuid(commit_uuid), .commit_wid(commit_wid), .commit_PC(commit_PC),
    .commit_tmask(commit_tmask), .commit_wb(commit_wb), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_eop(commit_eop),
`ifdef WB_PERF_EN
    .perf_wb_stalls(perf_wb_stalls),
`endif
    .writeback_valid(writeback_valid), .writeback_uuid(writeback_uuid),
    .writeback_wid(writeback_wid), .writeback_PC(writeback_PC),
    .writeback_tmask(writeback_tmask), .writeback_rd(writeback_rd),
    .writeback_data(writeback_data), .writeback_eop(writeback_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source-side stimulus state
  logic         v_a[N], wb_a[N], eop_a[N];
  logic [43:0]  uuid_a[N];
  logic [1:0]   wid_a[N];
  logic [4:0]   rd_a[N];
  logic [127:0] data_a[N];
  logic         oneshot;

  // Reference model state
  int      mptr;
  longint  mstall;
  wb_t     exp_q[$];
  wb_t     last;
  int      total, bad;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wb_t src_payload(input int i);
    wb_t p;
    p.uuid  = uuid_a[i];
    p.wid   = wid_a[i];
    p.pc    = 32'h8000_0000 + uuid_a[i][31:0];
    p.tmask = uuid_a[i][3:0] | 4'h1;
    p.rd    = rd_a[i];
    p.data  = data_a[i];
    p.eop   = eop_a[i];
    return p;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      wb_t p;
      p = src_payload(i);
      commit_valid[i]            = v_a[i];
      commit_wb[i]               = wb_a[i];
      commit_eop[i]              = p.eop;
      commit_uuid[i*44 +: 44]    = p.uuid;
      commit_wid[i*2 +: 2]       = p.wid;
      commit_PC[i*32 +: 32]      = p.pc;
      commit_tmask[i*4 +: 4]     = p.tmask;
      commit_rd[i*5 +: 5]        = p.rd;
      commit_data[i*128 +: 128]  = p.data;
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic wb, input logic [43:0] uuid,
                         input logic [1:0] wid, input logic [4:0] rd, input logic [127:0] data,
                         input logic eop);
    v_a[i] = v; wb_a[i] = wb; uuid_a[i] = uuid; wid_a[i] = wid;
    rd_a[i] = rd; data_a[i] = data; eop_a[i] = eop;
  endtask

  // One clock cycle: check ready mid-cycle, then the registered output after the edge.
  task automatic step(input logic rst);
    logic [N-1:0] exp_ready;
    int g, nwr;
    wb_t e;
    reset = rst;
    drive();
    g = -1; nwr = 0; exp_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (v_a[i] && wb_a[i]) nwr++;
      if (!rst && v_a[i] && !wb_a[i]) exp_ready[i] = 1'b1;
    end
    if (!rst) begin
      for (int j = 0; j < N; j++) begin
        int idx;
        idx = (mptr + j) % N;
        if (g < 0 && v_a[idx] && wb_a[idx]) g = idx;
      end
    end
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      exp_q.push_back(src_payload(g));
    end
    #4;
    check_val("commit_ready", commit_ready, exp_ready);
    @(posedge clk);
    #1;
    if (rst) begin
      mptr = 0; mstall = 0; last = '0;
      check_val("rst_valid", writeback_valid, 1'b0);
      check_val("rst_uuid", writeback_uuid, 44'd0);
      check_val("rst_rd", writeback_rd, 5'd0);
      check_val("rst_data", writeback_data, 128'd0);
    end else begin
      if (nwr > 1) mstall++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("wb_valid", writeback_valid, 1'b1);
        check_val("wb_uuid", writeback_uuid, e.uuid);
        check_val("wb_wid", writeback_wid, e.wid);
        check_val("wb_pc", writeback_PC, e.pc);
        check_val("wb_tmask", writeback_tmask, e.tmask);
        check_val("wb_rd", writeback_rd, e.rd);
        check_val("wb_data", writeback_data, e.data);
        check_val("wb_eop", writeback_eop, e.eop);
        last = e;
      end else begin
        check_val("idle_valid", writeback_valid, 1'b0);
        check_val("hold_rd", writeback_rd, last.rd);
        check_val("hold_data", writeback_data, last.data);
      end
      if (g >= 0) begin
        mptr = (g + 1) % N;
        if (oneshot) v_a[g] = 1'b0;
        else uuid_a[g] = uuid_a[g] + 44'd16;
      end
    end
`ifdef WB_PERF_EN
    check_val("perf_stalls", perf_wb_stalls, 128'(mstall));
`endif
  endtask

  initial begin
    total = 0; bad = 0; mptr = 0; mstall = 0; last = '0; oneshot = 1'b1;
    for (int i = 0; i < N; i++)
      set_src(i, 1'b0, 1'b0, 44'(100 * (i + 1)), 2'(i), 5'(i + 1), 128'(i), 1'b1);
    #1;
    step(1'b1);
    step(1'b1);

    // Single ALU commit with fixed payload
    set_src(0, 1'b1, 1'b1, 44'h123, 2'd2, 5'd7, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
    step(1'b0);
    step(1'b0);

    // Drops on CSR and GPU
    set_src(2, 1'b1, 1'b0, 44'h200, 2'd1, 5'd3, 128'hdead, 1'b1);
    set_src(4, 1'b1, 1'b0, 44'h400, 2'd3, 5'd9, 128'hbeef, 1'b0);
    step(1'b0);
    v_a[2] = 1'b0; v_a[4] = 1'b0;

    // LSU writing plus FPU drop in the same cycle (pointer still 1 after the drops)
    set_src(1, 1'b1, 1'b1, 44'h511, 2'd1, 5'd12, {32'hA, 32'hB, 32'hC, 32'hD}, 1'b0);
    set_src(3, 1'b1, 1'b0, 44'h533, 2'd3, 5'd13, 128'h77, 1'b1);
    step(1'b0);
    v_a[3] = 1'b0;
    step(1'b0);

    // Round robin: all five hold writing requests from reset
    step(1'b1);
    oneshot = 1'b0;
    for (int i = 0; i < N; i++)
      set_src(i, 1'b1, 1'b1, 44'(1000 + 37 * i), 2'(i), 5'(20 + i), 128'(64'h1111 * (i + 1)), 1'(i % 2));
    for (int k = 0; k < 5; k++) step(1'b0);
    for (int i = 1; i < N; i++) v_a[i] = 1'b0;
    step(1'b0);
    v_a[0] = 1'b0;
    step(1'b0);

    // Wrap and skip: move pointer to 4, then sources 1 and 3
    oneshot = 1'b1;
    v_a[3] = 1'b1; wb_a[3] = 1'b1;
    step(1'b0);
    v_a[1] = 1'b1; v_a[3] = 1'b1; wb_a[1] = 1'b1;
    step(1'b0);
    step(1'b0);
    step(1'b0);
    v_a[0] = 1'b1; v_a[4] = 1'b1; wb_a[0] = 1'b1; wb_a[4] = 1'b1;
    step(1'b0);
    step(1'b0);

    // Reset one cycle after a grant, held requests resume from index 0
    oneshot = 1'b0;
    v_a[2] = 1'b1; wb_a[2] = 1'b1;
    v_a[3] = 1'b1; wb_a[3] = 1'b1;
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    v_a[2] = 1'b0; v_a[3] = 1'b0;
    step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
